// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit multiplexed 7-segment scanner.
package display_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] ANODES_OFF = 4'b1111;

    typedef logic [1:0] slot_t;

    // Active-low one-hot anode for a lit slot.
    function automatic logic [3:0] anode_sel(input slot_t s);
        anode_sel = ~(4'b0001 << s);
    endfunction

    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input slot_t s);
        nibble_sel = v[{s, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// Interface between the display scanner and its host/decoder side.
interface display_scan_if;
    import display_pkg::*;

    logic        load;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  display_data;
    logic [3:0]  an;
    logic        blank;
    slot_t       slot;
    logic        frame_done;

    modport master (
        output load, value, digit_en,
        input  display_data, an, blank, slot, frame_done
    );

    modport slave (
        input  load, value, digit_en,
        output display_data, an, blank, slot, frame_done
    );

endinterface

// File: rtl/display_scan_tick_gen.sv
// Slot timebase: counts clocks per digit slot, flags the last clock (tick) and
// whether the upcoming cycle falls inside the anode dead window.
module scan_tick_gen #(
    parameter int TICK_DIV    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic in_dead
);

    localparam int             CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  DEAD = CW'(DEAD_CYCLES);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;

    // Next count and tick; in_dead refers to the next count so the top can register outputs from it.
    always_comb begin
        tick      = (cnt_r == LAST);
        cnt_nxt_s = cnt_r;
        if (tick) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
        in_dead = (cnt_nxt_s < DEAD);
    end

    // Slot counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/display_scan.sv
// Four-digit common-anode display scanner with frame-synchronous value update.
// Optional leading-zero blanking when DISPLAY_SCAN_LZB_EN is defined.
module display_scan
    import display_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    display_scan_if.slave  bus
);

    logic        tick_s;
    logic        in_dead_s;
    logic        boundary_s;
    slot_t       slot_r;
    slot_t       slot_nxt_s;
    logic [15:0] active_r;
    logic [15:0] active_nxt_s;
    logic [15:0] pending_r;
    logic [15:0] pending_nxt_s;
    logic        pend_v_r;
    logic        pend_v_nxt_s;
    logic [3:0]  lz_dark_s;
    logic        dark_s;

    scan_tick_gen #(
        .TICK_DIV    (TICK_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick_s),
        .in_dead (in_dead_s)
    );

    // Slot advance and double-buffered value update; a load on the boundary bypasses pending.
    always_comb begin
        slot_nxt_s    = slot_r;
        active_nxt_s  = active_r;
        pending_nxt_s = pending_r;
        pend_v_nxt_s  = pend_v_r;
        boundary_s    = tick_s && (slot_r == 2'd3);
        if (tick_s) begin
            slot_nxt_s = slot_r + 2'd1;
        end else begin
            slot_nxt_s = slot_r;
        end
        if (boundary_s && bus.load) begin
            active_nxt_s  = bus.value;
            pending_nxt_s = bus.value;
            pend_v_nxt_s  = 1'b0;
        end else if (bus.load) begin
            pending_nxt_s = bus.value;
            pend_v_nxt_s  = 1'b1;
        end else if (boundary_s && pend_v_r) begin
            active_nxt_s = pending_r;
            pend_v_nxt_s = 1'b0;
        end else begin
            pend_v_nxt_s = pend_v_r;
        end
    end

    // Dark decision for the upcoming cycle; digit 0 is never leading-zero blanked.
    always_comb begin
`ifdef DISPLAY_SCAN_LZB_EN
        lz_dark_s = {(active_nxt_s[15:12] == 4'h0),
                     (active_nxt_s[15:8]  == 8'h00),
                     (active_nxt_s[15:4]  == 12'h000),
                     1'b0};
`else
        lz_dark_s = 4'b0000;
`endif
        dark_s = in_dead_s || !bus.digit_en[slot_nxt_s] || lz_dark_s[slot_nxt_s];
    end

    // State and output registers; outputs are built from next-state so they move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r           <= 2'd0;
            active_r         <= 16'h0000;
            pending_r        <= 16'h0000;
            pend_v_r         <= 1'b0;
            bus.an           <= ANODES_OFF;
            bus.display_data <= 4'h0;
            bus.blank        <= 1'b1;
            bus.frame_done   <= 1'b0;
        end else begin
            slot_r           <= slot_nxt_s;
            active_r         <= active_nxt_s;
            pending_r        <= pending_nxt_s;
            pend_v_r         <= pend_v_nxt_s;
            bus.an           <= dark_s ? ANODES_OFF : anode_sel(slot_nxt_s);
            bus.display_data <= nibble_sel(active_nxt_s, slot_nxt_s);
            bus.blank        <= dark_s;
            bus.frame_done   <= boundary_s;
        end
    end

    assign bus.slot = slot_r;

endmodule

// File: tb/tb_display_scan.sv
// Directed self-checking bench for display_scan with TICK_DIV=4, DEAD_CYCLES=1.
module tb_display_scan;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    display_scan_if ifc ();

    display_scan #(
        .TICK_DIV    (4),
        .DEAD_CYCLES (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Walk one 16-cycle frame starting at the cycle right after a boundary.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] en, input string tag);
        logic [3:0] lz;
        logic       dark;
        logic [3:0] exp_an;
        logic [3:0] exp_d;
        int         s;
        int         c;
        lz = 4'b0000;
`ifdef DISPLAY_SCAN_LZB_EN
        lz[3] = (v[15:12] == 4'h0);
        lz[2] = (v[15:8]  == 8'h00);
        lz[1] = (v[15:4]  == 12'h000);
`endif
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            s      = k / 4;
            c      = k % 4;
            dark   = (c == 0) || !en[s] || lz[s];
            exp_an = dark ? 4'b1111 : ~(4'b0001 << s);
            exp_d  = v[4*s +: 4];
            checks++;
            if (ifc.slot !== 2'(s)) begin
                failures++;
                $display("FAIL %s slot k=%0d got=%0d exp=%0d", tag, k, ifc.slot, s);
            end
            checks++;
            if (ifc.an !== exp_an) begin
                failures++;
                $display("FAIL %s an k=%0d got=%b exp=%b", tag, k, ifc.an, exp_an);
            end
            checks++;
            if (ifc.display_data !== exp_d) begin
                failures++;
                $display("FAIL %s data k=%0d got=%h exp=%h", tag, k, ifc.display_data, exp_d);
            end
            checks++;
            if (ifc.blank !== dark) begin
                failures++;
                $display("FAIL %s blank k=%0d got=%b exp=%b", tag, k, ifc.blank, dark);
            end
            checks++;
            if (ifc.frame_done !== (k == 0)) begin
                failures++;
                $display("FAIL %s frame_done k=%0d got=%b exp=%b", tag, k, ifc.frame_done, (k == 0));
            end
        end
    endtask

    task automatic wait_frame_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ifc.frame_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s frame_done timeout got=0 exp=1", tag);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        ifc.load  = 1'b1;
        ifc.value = v;
        @(negedge clk);
        ifc.load  = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (ifc.an !== 4'b1111) begin failures++; $display("FAIL reset an got=%b exp=1111", ifc.an); end
        checks++;
        if (ifc.blank !== 1'b1) begin failures++; $display("FAIL reset blank got=%b exp=1", ifc.blank); end
        checks++;
        if (ifc.slot !== 2'd0) begin failures++; $display("FAIL reset slot got=%0d exp=0", ifc.slot); end
        checks++;
        if (ifc.display_data !== 4'h0) begin failures++; $display("FAIL reset data got=%h exp=0", ifc.display_data); end
        checks++;
        if (ifc.frame_done !== 1'b0) begin failures++; $display("FAIL reset frame_done got=%b exp=0", ifc.frame_done); end
    endtask

    task automatic test_basic_load;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc.an !== 4'b1110) begin failures++; $display("FAIL first_lit an got=%b exp=1110", ifc.an); end
        @(negedge clk);
        pulse_load(16'h1234);
        checks++;
        if (ifc.display_data !== 4'h0) begin failures++; $display("FAIL early_apply data got=%h exp=0", ifc.display_data); end
        wait_frame_done("basic");
        check_frame(16'h1234, 4'b1111, "basic");
    endtask

    task automatic test_last_wins;
        wait_frame_done("last_wins");
        pulse_load(16'hAAAA);
        pulse_load(16'h5555);
        wait_frame_done("last_wins");
        check_frame(16'h5555, 4'b1111, "last_wins");
    endtask

    task automatic test_boundary_load;
        wait_frame_done("bnd");
        pulse_load(16'h1111);
        repeat (14) @(negedge clk);
        pulse_load(16'hBEEF);
        check_frame(16'hBEEF, 4'b1111, "bnd_first");
        @(negedge clk);
        check_frame(16'hBEEF, 4'b1111, "bnd_second");
    endtask

    task automatic test_digit_en;
        ifc.digit_en = 4'b0101;
        pulse_load(16'hFFFF);
        wait_frame_done("den");
        check_frame(16'hFFFF, 4'b0101, "den");
        wait_frame_done("den_live");
        @(negedge clk);
        @(negedge clk);
        ifc.digit_en = 4'b0000;
        @(negedge clk);
        checks++;
        if (ifc.an !== 4'b1111 || ifc.blank !== 1'b1) begin
            failures++;
            $display("FAIL den_off an/blank got=%b/%b exp=1111/1", ifc.an, ifc.blank);
        end
        ifc.digit_en = 4'b1111;
        repeat (2) @(negedge clk);
        checks++;
        if (ifc.an !== 4'b1101) begin failures++; $display("FAIL den_on an got=%b exp=1101", ifc.an); end
    endtask

    task automatic test_lzb;
        wait_frame_done("lzb");
        pulse_load(16'h0070);
        wait_frame_done("lzb");
        check_frame(16'h0070, 4'b1111, "lzb_0070");
        wait_frame_done("lzb");
        pulse_load(16'h0000);
        wait_frame_done("lzb");
        check_frame(16'h0000, 4'b1111, "lzb_0000");
    endtask

    task automatic test_reset_mid;
        wait_frame_done("rstm");
        pulse_load(16'h0900);
        wait_frame_done("rstm");
        repeat (9) @(negedge clk);
        checks++;
        if (ifc.an !== 4'b1011 || ifc.display_data !== 4'h9) begin
            failures++;
            $display("FAIL rstm_pre an/data got=%b/%h exp=1011/9", ifc.an, ifc.display_data);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ifc.an !== 4'b1111) begin failures++; $display("FAIL rstm an got=%b exp=1111", ifc.an); end
        checks++;
        if (ifc.slot !== 2'd0) begin failures++; $display("FAIL rstm slot got=%0d exp=0", ifc.slot); end
        checks++;
        if (ifc.blank !== 1'b1 || ifc.display_data !== 4'h0) begin
            failures++;
            $display("FAIL rstm blank/data got=%b/%h exp=1/0", ifc.blank, ifc.display_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (ifc.frame_done !== (k == 16)) begin
                failures++;
                $display("FAIL rstm frame_done k=%0d got=%b exp=%b", k, ifc.frame_done, (k == 16));
            end
            if (k == 1) begin
                checks++;
                if (ifc.an !== 4'b1110 || ifc.display_data !== 4'h0) begin
                    failures++;
                    $display("FAIL rstm_post an/data got=%b/%h exp=1110/0", ifc.an, ifc.display_data);
                end
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        ifc.load     = 1'b0;
        ifc.value    = 16'h0000;
        ifc.digit_en = 4'b1111;
        test_reset();
        test_basic_load();
        test_last_wins();
        test_boundary_load();
        test_digit_en();
        test_lzb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed driver for the board's four-digit common-anode 7-segment display, sitting directly upstream of the hex-to-segment decoder. It captures a 16-bit value and splits it into four nibbles. It rotates through the digits at a fixed refresh rate, presenting one nibble per slot on `display_data` with the matching active-low anode, so the decoder turns that nibble into cathode bits. New values are applied only at frame boundaries, so a digit never shows a value that was partly overwritten during the scan.

## Interface
- `TICK_DIV`, 100000: clocks per digit slot (1 ms at 100 MHz); must be ≥ 2.
- `DEAD_CYCLES`, 1000: clocks at the start of each slot with all anodes off (ghosting guard); must be < `TICK_DIV`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: one-cycle strobe; capture `value` into pending register.
- `value` in 16: digit3 = [15:12] … digit0 = [3:0].
- `digit_en` in 4: per-digit enable, sampled live; 0 forces the digit dark.
- `display_data` out 4: nibble of current slot, to decoder input.
- `an` out 4: active-low anode select, one-hot-low or all-high.
- `blank` out 1: high when current slot is dark (`an` all-high).
- `slot` out 2: index of current digit.
- `frame_done` out 1: one-cycle pulse when slot wraps 3→0.

## Operation
- Registers: `cnt` (0..TICK_DIV-1), `slot`, `active[15:0]`, `pending[15:0]`, `pend_v`.
- `cnt` increments every clock. At `cnt==TICK_DIV-1`, it returns to 0 and `slot` increments mod 4. This cycle is the "tick".
- Tick with `slot==3`: the frame boundary.
  - `frame_done` pulses.
  - If `pend_v`, then `active<=pending` and `pend_v<=0`.
- `load` sets `pending<=value` and `pend_v<=1`. A later `load` before the boundary overwrites it (last wins).
- `load` in the same cycle as a boundary tick: `value` goes straight to `active`, and `pend_v` ends at 0.
- Dark condition for a slot: `cnt < DEAD_CYCLES`, or `digit_en[slot]==0`, or (if configured) leading-zero blanked.
- Outputs are registered from next-state values, so `an`, `display_data`, `blank` and `slot` change in the same edge.
  - Lit slot: `an = ~(4'b0001<<slot)`, `display_data = active[4*slot+:4]`, `blank=0`.
  - Dark slot: `an=4'b1111`, `blank=1`, and `display_data` still carries the slot's nibble.
- No FSM beyond the slot counter; scan order is fixed 0,1,2,3,0…

## Timing
- Reset values: `cnt=0`, `slot=0`, `active=0`, `pending=0`, `pend_v=0`, `an=4'b1111`, `display_data=0`, `blank=1`, `frame_done=0`.
- Reset asserted mid-scan clears everything immediately and asynchronously. The first lit digit after release is slot 0, at clock `DEAD_CYCLES` after release.
- Slot period is `TICK_DIV` clocks; frame period is `4*TICK_DIV` clocks.
- `load`→display latency: at most `4*TICK_DIV` clocks plus the dead time of slot 0.
- `frame_done` is high for exactly one clock and coincides with `slot` becoming 0.
- A `digit_en` change takes effect on the next clock edge.

## Configuration
- `DISPLAY_SCAN_LZB_EN` defined: leading-zero blanking.
  - Digit i (i=3..1) is dark when `active[15:4*i]==0`.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- Undefined: all enabled digits are shown, including leading zeros.

## Structure
- Shared package `display_pkg`:
  - `NUM_DIGITS=4`
  - `ANODES_OFF=4'b1111`
  - `slot_t` typedef (2-bit)
- One natural sub-module, `scan_tick_gen`: holds `cnt`, outputs `tick` and `in_dead`, and is parameterised by `TICK_DIV` and `DEAD_CYCLES`.
- Nibble select, anode decode and blanking stay in `display_scan`.

## Test plan
(Use `TICK_DIV=4`, `DEAD_CYCLES=1`.)
1. Reset, then `load` `16'h1234` at cycle 2 → after the first boundary, slots 0..3 show `display_data` 4,3,2,1 with `an` 1110,1101,1011,0111. Each slot has 1 dark cycle then 3 lit cycles.
2. Load `16'hAAAA`, then `16'h5555` within one frame → only `5555` is displayed. `active` never equals `AAAA` at a boundary.
3. `load` `16'hBEEF` exactly on the slot-3 tick → slot 0 immediately lit with `F`. `pend_v==0`.
4. `digit_en=4'b0101` with `active=16'hFFFF` → slots 1 and 3 keep `an=1111` and `blank=1`. Slots 0 and 2 light.
5. With `DISPLAY_SCAN_LZB_EN`, `active=16'h0070` → digits 3 and 2 are dark, digits 1 and 0 show 7 and 0. Without the macro, all four are lit.
6. Assert `rst_n` low mid-slot 2 → `an=1111` and `slot=0` with no clock edge. After release, `frame_done` first pulses 16 clocks later.
